// File: rtl/sram_req_bridge.sv
// Byte-addressed valid/ready to single-cycle SRAM bridge with in-order, credit-limited responses.
// Define SRAM_REQ_BRIDGE_STATS_EN to enable the saturating read/write/error statistics counters.
module sram_req_bridge #(
   parameter int unsigned Width      = 32,
   parameter int unsigned Depth      = 1 << 15,
   parameter logic [31:0] BaseAddr   = 32'h8000_0000,
   parameter int unsigned RspDepth   = 4,
   localparam int unsigned WidthBytes = Width / 8,
   localparam int unsigned Aw         = $clog2(Depth)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [31:0]           req_addr_i,
   input  logic [Width-1:0]      req_wdata_i,
   input  logic [WidthBytes-1:0] req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [Width-1:0]      rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_we_o,
   output logic                  sram_req_o,
   output logic                  sram_write_o,
   output logic [Aw-1:0]         sram_addr_o,
   output logic [Width-1:0]      sram_wdata_o,
   output logic [WidthBytes-1:0] sram_wmask_o,
   input  logic [Width-1:0]      sram_rdata_i,
   output logic [31:0]           stat_rd_o,
   output logic [31:0]           stat_wr_o,
   output logic [31:0]           stat_err_o
);

   localparam int unsigned Ob        = $clog2(WidthBytes);
   localparam int unsigned Pw        = $clog2(RspDepth);
   localparam int unsigned Cw        = $clog2(RspDepth + 1);
   localparam logic [32:0] Span      = 33'(Depth * WidthBytes);
   localparam logic [31:0] LowMask   = 32'(WidthBytes - 1);
   localparam logic [Cw-1:0] CreditMax = Cw'(RspDepth);

   logic [31:0]      w_off;
   logic             w_err;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic [Cw-1:0]    w_occ;
   logic [Width-1:0] w_cap_rdata;

   logic             r_pend_valid;
   logic             r_pend_we;
   logic             r_pend_err;

   logic [Width-1:0] r_fifo_rdata [RspDepth];
   logic             r_fifo_err   [RspDepth];
   logic             r_fifo_we    [RspDepth];
   logic [Pw-1:0]    r_wptr;
   logic [Pw-1:0]    r_rptr;
   logic [Cw-1:0]    r_count;

   assign w_off = req_addr_i - BaseAddr;
   assign w_err = (req_addr_i < BaseAddr) | ({1'b0, w_off} >= Span) |
                  ((req_addr_i & LowMask) != '0);

   // Credits count the pending capture slot too, so the FIFO can never overflow.
   assign w_occ       = r_count + Cw'(r_pend_valid);
   assign req_ready_o = rst_ni & (w_occ < CreditMax);
   assign w_accept    = req_valid_i & req_ready_o;

   assign sram_req_o   = w_accept & ~w_err;
   assign sram_write_o = req_we_i;
   assign sram_addr_o  = w_off[Ob+Aw-1:Ob];
   assign sram_wdata_o = req_wdata_i;
   assign sram_wmask_o = req_be_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pend_valid <= 1'b0;
         r_pend_we    <= 1'b0;
         r_pend_err   <= 1'b0;
      end else begin
         r_pend_valid <= w_accept;
         if (w_accept) begin
            r_pend_we  <= req_we_i;
            r_pend_err <= w_err;
         end
      end
   end

   assign w_push      = r_pend_valid;
   assign w_pop       = rsp_valid_o & rsp_ready_i;
   assign w_cap_rdata = (r_pend_we | r_pend_err) ? '0 : sram_rdata_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < RspDepth; i++) begin
            r_fifo_rdata[i] <= '0;
            r_fifo_err[i]   <= 1'b0;
            r_fifo_we[i]    <= 1'b0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo_rdata[r_wptr] <= w_cap_rdata;
            r_fifo_err[r_wptr]   <= r_pend_err;
            r_fifo_we[r_wptr]    <= r_pend_we;
            r_wptr               <= r_wptr + Pw'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + Pw'(1);
         end
         r_count <= r_count + Cw'(w_push) - Cw'(w_pop);
      end
   end

   assign rsp_valid_o = (r_count != '0);
   assign rsp_rdata_o = r_fifo_rdata[r_rptr];
   assign rsp_err_o   = r_fifo_err[r_rptr];
   assign rsp_we_o    = r_fifo_we[r_rptr];

`ifdef SRAM_REQ_BRIDGE_STATS_EN
   logic [31:0] r_stat_rd;
   logic [31:0] r_stat_wr;
   logic [31:0] r_stat_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_stat_rd  <= '0;
         r_stat_wr  <= '0;
         r_stat_err <= '0;
      end else if (w_accept) begin
         if (w_err) begin
            if (r_stat_err != '1) r_stat_err <= r_stat_err + 32'd1;
         end else if (req_we_i) begin
            if (r_stat_wr != '1) r_stat_wr <= r_stat_wr + 32'd1;
         end else begin
            if (r_stat_rd != '1) r_stat_rd <= r_stat_rd + 32'd1;
         end
      end
   end

   assign stat_rd_o  = r_stat_rd;
   assign stat_wr_o  = r_stat_wr;
   assign stat_err_o = r_stat_err;
`else
   assign stat_rd_o  = '0;
   assign stat_wr_o  = '0;
   assign stat_err_o = '0;
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Directed bench for sram_req_bridge: behavioural SRAM, reference memory and in-order response scoreboard.
module tb_sram_req_bridge;

   localparam int unsigned Depth = 1 << 15;
   localparam logic [31:0] Base  = 32'h8000_0000;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        we;
      int          acc;
      bit          exact;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, rsp_valid, rsp_err, rsp_we;
   logic [31:0] rsp_rdata;
   logic        sram_req, sram_write;
   logic [14:0] sram_addr;
   logic [31:0] sram_wdata, sram_rdata = '0;
   logic [3:0]  sram_wmask;
   logic [31:0] stat_rd, stat_wr, stat_err;

   logic [31:0] mem     [Depth];
   logic [31:0] ref_mem [Depth];
   exp_t        sbq[$];
   int          errors = 0, checks = 0;
   int          cyc = 0, stalls = 0, strobes = 0;
   int unsigned n_rd = 0, n_wr = 0, n_err = 0;

   sram_req_bridge #(.Width(32), .Depth(Depth), .BaseAddr(Base), .RspDepth(4)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_we_o(rsp_we),
      .sram_req_o(sram_req), .sram_write_o(sram_write), .sram_addr_o(sram_addr),
      .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata),
      .stat_rd_o(stat_rd), .stat_wr_o(stat_wr), .stat_err_o(stat_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Behavioural single-cycle SRAM with one cycle of read latency.
   always @(posedge clk) begin
      logic [31:0] w;
      if (sram_req) begin
         if (sram_write) begin
            w = mem[sram_addr];
            for (int b = 0; b < 4; b++)
               if (sram_wmask[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[sram_addr] <= w;
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat_exp(input int unsigned n);
`ifdef SRAM_REQ_BRIDGE_STATS_EN
      return n;
`else
      return 32'd0 & n;
`endif
   endfunction

   always @(negedge clk) begin
      if (sram_req) strobes++;
      if (!rst_ni) check("strobe_in_reset", {31'd0, sram_req}, 32'd0);
   end

   // Response side: every handshake is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_ni && rsp_valid && rsp_ready) begin
         if (sbq.size() == 0) begin
            check("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            check("rsp_we", {31'd0, rsp_we}, {31'd0, e.we});
            if (e.exact) check("rsp_latency", 32'(cyc - e.acc), 32'd2);
            else         check("rsp_latency_min", {31'd0, (cyc - e.acc) >= 2}, 32'd1);
         end
      end
   end

   // Called at the negedge of the cycle in which the request is accepted.
   task automatic accept_now(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, input bit exact);
      exp_t        e;
      logic        err;
      logic [31:0] idx;
      err = (addr < Base) || (addr >= Base + Depth * 4) || (addr[1:0] != 2'b00);
      idx = (addr - Base) >> 2;
      check("sram_req", {31'd0, sram_req}, {31'd0, !err});
      if (!err) begin
         check("sram_addr", {17'd0, sram_addr}, idx);
         check("sram_write", {31'd0, sram_write}, {31'd0, we});
         if (we) begin
            check("sram_wdata", sram_wdata, wd);
            check("sram_wmask", {28'd0, sram_wmask}, {28'd0, be});
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[idx[14:0]][8*b +: 8] = wd[8*b +: 8];
         end
      end
      e.rdata = (!we && !err) ? ref_mem[idx[14:0]] : 32'd0;
      e.err   = err;
      e.we    = we;
      e.acc   = cyc;
      e.exact = exact;
      sbq.push_back(e);
      if (err) n_err++;
      else if (we) n_wr++;
      else n_rd++;
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
   endtask

   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit exact);
      drive(we, addr, wd, be);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (req_ready) begin
            accept_now(we, addr, wd, be, exact);
            @(posedge clk); #1;
            return;
         end
         stalls++;
         @(posedge clk); #1;
      end
      check("req_ready_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle();
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 200; k++) begin
         if (sbq.size() == 0 && !rsp_valid) break;
         @(negedge clk);
      end
      check("drain_queue", 32'(sbq.size()), 32'd0);
      check("drain_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, cyc0, str0, st0;
      for (int unsigned i = 0; i < Depth; i++) begin
         mem[i]     = (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
         ref_mem[i] = (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
      end

      // Reset state, with a request held valid to prove it is not accepted.
      drive(1'b0, Base, 32'd0, 4'hF);
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("rst_rsp_we", {31'd0, rsp_we}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_sram_req", {31'd0, sram_req}, 32'd0);
      check("rst_stat_err", stat_err, 32'd0);
      @(negedge clk); rst_ni = 1'b1; idle();
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);

      // Write then read back the same word, both at minimum latency.
      issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1);
      issue(1'b0, 32'h8000_0010, 32'd0, 4'h0, 1'b1);
      idle();
      wait_drain();

      // Below base, misaligned, one past the end.
      str0 = strobes;
      issue(1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 1'b1);
      issue(1'b0, 32'h8000_0002, 32'd0, 4'h0, 1'b1);
      issue(1'b0, Base + Depth * 4, 32'd0, 4'h0, 1'b1);
      idle();
      wait_drain();
      check("err_no_strobe", 32'(strobes - str0), 32'd0);
      check("stat_err", stat_err, stat_exp(n_err));
      check("stat_rd", stat_rd, stat_exp(n_rd));
      check("stat_wr", stat_wr, stat_exp(n_wr));

      // Backpressure: only four credits are available.
      rsp_ready = 1'b0;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b0, Base + 32'h100 + 4 * n, 32'd0, 4'h0);
         @(negedge clk);
         if (req_ready) begin
            accept_now(1'b0, Base + 32'h100 + 4 * n, 32'd0, 4'h0, 1'b0);
            n++;
         end
         @(posedge clk); #1;
      end
      idle();
      check("bp_accepts", 32'(n), 32'd4);
      check("bp_ready_low", {31'd0, req_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      for (int k = n; k < 6; k++) issue(1'b0, Base + 32'h100 + 4 * k, 32'd0, 4'h0, 1'b0);
      idle();
      wait_drain();

      // Sustained throughput.
      cyc0 = cyc; str0 = strobes; st0 = stalls;
      for (int k = 0; k < 100; k++) issue(1'b0, Base + 32'h400 + 4 * k, 32'd0, 4'h0, 1'b0);
      idle();
      check("burst_cycles", 32'(cyc - cyc0), 32'd100);
      check("burst_stalls", 32'(stalls - st0), 32'd0);
      check("burst_strobes", 32'(strobes - str0), 32'd100);
      wait_drain();

      // Partial write over a known word.
      issue(1'b1, 32'h8000_0200, 32'hAABB_CCDD, 4'hF, 1'b0);
      issue(1'b1, 32'h8000_0200, 32'h1122_3344, 4'b0101, 1'b0);
      issue(1'b0, 32'h8000_0200, 32'd0, 4'h0, 1'b0);
      idle();
      wait_drain();
      check("mask_ref", ref_mem[128], 32'hAA22_CC44);
      str0 = strobes;
      issue(1'b1, 32'h8000_0204, 32'hFFFF_FFFF, 4'h0, 1'b0);
      idle();
      check("be0_strobes", 32'(strobes - str0), 32'd1);
      wait_drain();
      check("stat_wr_final", stat_wr, stat_exp(n_wr));

      // Reset with three responses queued.
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) issue(1'b0, Base + 32'h40 + 4 * k, 32'd0, 4'h0, 1'b0);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("queued_valid", {31'd0, rsp_valid}, 32'd1);
      drive(1'b0, Base + 32'h50, 32'd0, 4'h0);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("mid_rst_sram_req", {31'd0, sram_req}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
      check("mid_rst_stat_rd", stat_rd, 32'd0);
      sbq.delete();
      n_rd = 0; n_wr = 0; n_err = 0;
      @(negedge clk); rst_ni = 1'b1; idle();
      @(posedge clk); #1;
      check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
      rsp_ready = 1'b1;
      issue(1'b0, 32'h8000_0200, 32'd0, 4'h0, 1'b1);
      idle();
      wait_drain();
      check("post_rst_stat_rd", stat_rd, stat_exp(n_rd));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
